// File: rtl/bist_pattern_sequencer.sv
// BIST sweep controller: resets a small benchmark, applies every input vector in
// ascending order, samples its single output and compacts the responses into a MISR.
module bist_pattern_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden,
  input  logic             dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             dut_reset,
  output logic             busy,
  output logic             sample_valid,
  output logic [N_IN-1:0]  sample_vec,
  output logic             sample_bit,
  output logic [SIG_W-1:0] signature,
  output logic             done,
  output logic             pass
);

  localparam int             HOLD_CYC = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [3:0]     HOLD_END = 4'(HOLD_CYC - 1);
  localparam logic [N_IN:0]  LAST_VEC = {1'b0, {N_IN{1'b1}}};

  typedef enum logic [2:0] {IDLE, DRST, HOLD, SAMPLE, DONE} state_t;

  state_t        state, state_n;
  logic [N_IN:0] vec;
  logic [3:0]    cnt;
  logic          fb;
  logic          active;

  assign active = (state == DRST) || (state == HOLD) || (state == SAMPLE);
  assign busy   = active;
  assign done   = (state == DONE);
  assign fb     = signature[SIG_W-1] ^ signature[SIG_W-3] ^ signature[SIG_W-4] ^
                  signature[SIG_W-6] ^ dut_out;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = abort ? IDLE : DRST;
      DRST:       state_n = HOLD;
      HOLD:       if (cnt == HOLD_END) state_n = SAMPLE;
      SAMPLE:     state_n = (vec == LAST_VEC) ? DONE : HOLD;
      default:    state_n = IDLE;
    endcase
    if (abort && active) state_n = IDLE;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      vec          <= '0;
      cnt          <= '0;
      dut_in       <= '0;
      dut_reset    <= 1'b0;
      sample_valid <= 1'b0;
      sample_vec   <= '0;
      sample_bit   <= 1'b0;
      signature    <= '0;
      pass         <= 1'b0;
    end else begin
      state        <= state_n;
      dut_reset    <= (state_n == DRST);
      sample_valid <= 1'b0;
      case (state)
        HOLD: begin
          // The strobe is raised on entry to SAMPLE so the signature seen with it
          // already includes this vector's response.
          if (state_n == SAMPLE) begin
            sample_valid <= 1'b1;
            sample_vec   <= vec[N_IN-1:0];
            sample_bit   <= dut_out;
            signature    <= {signature[SIG_W-2:0], fb};
            cnt          <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (state_n == HOLD) begin
            vec    <= vec + 1'b1;
            dut_in <= vec[N_IN-1:0] + 1'b1;
          end else if (state_n == DONE) begin
            pass <= (signature == golden);
          end
        end
        default: ;
      endcase
      if (state_n == DRST) begin
        signature <= '0;
        pass      <= 1'b0;
        vec       <= '0;
        cnt       <= '0;
        dut_in    <= '0;
      end
      if (state_n == IDLE && state != IDLE) begin
        dut_in <= '0;
        pass   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bist_pattern_sequencer.md
Name: bist_pattern_sequencer

Overview:
On-chip stimulus and response controller for the small benchmark circuits in the trojan-detection suite. It drives a benchmark's primary inputs through every vector in ascending binary order and pulses the benchmark reset before the first vector. After each vector settles it samples the single output and folds it into a MISR signature. It streams each (vector, response) pair for logging and compares the final signature against a golden value. It sits between a bench or host and one benchmark instance, and replaces open-loop fixed-delay pattern application with a clocked, handshaked sequence.

Parameters:
N_IN, 3, number of benchmark primary inputs; the sweep covers 2^N_IN vectors.
SETTLE, 1, cycles each vector is held before sampling; legal range 0..15.
SIG_W, 16, signature width; the tap set below is fixed for 16.

Ports:
CK  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high, controller reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
abort  input  1  ends a sweep in progress; returns to IDLE without asserting done.
golden  input  SIG_W  expected signature; sampled when the sweep finishes.
dut_out  input  1  benchmark output.
dut_in  output  N_IN  benchmark inputs, registered; MSB maps to N[0] of the benchmark.
dut_reset  output  1  registered reset pulse to the benchmark.
busy  output  1  high from the cycle after an accepted start until DONE or IDLE.
sample_valid  output  1  one-cycle strobe for each sampled vector.
sample_vec  output  N_IN  vector that belongs to the current sample_valid.
sample_bit  output  1  dut_out value captured with sample_valid.
signature  output  SIG_W  running MISR value.
done  output  1  level; high in DONE.
pass  output  1  valid while done is high; 1 when signature equals the latched golden.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; internal vector and settle counters are 0.
- States: IDLE, DRST, HOLD, SAMPLE, DONE.
- IDLE/DONE + start: signature clears to 0 and done/pass clear. Next state is DRST.
- DRST, 1 cycle: dut_reset=1 and dut_in=0. Next state is HOLD with vec=0.
- HOLD: dut_in=vec and dut_reset=0. Stays SETTLE cycles; with SETTLE=0 it lasts 1 cycle.
- SAMPLE, 1 cycle:
  - Capture dut_out and assert sample_valid with sample_vec=vec and sample_bit=dut_out.
  - Update the MISR: fb = sig[15]^sig[13]^sig[12]^sig[10]^dut_out; sig <= {sig[14:0], fb}.
  - If vec == 2^N_IN-1, go to DONE. Otherwise increment vec, set dut_in to the new vec, and go to HOLD.
- Cycle count: each vector takes max(SETTLE,1)+1 cycles. A full sweep from accepted start to done=1 is 1 + 2^N_IN*(max(SETTLE,1)+1) + 1 cycles.
- DONE:
  - done=1 and busy=0.
  - pass = (signature == golden); golden is latched on the entry cycle.
  - signature, dut_in and pass hold until the next start.
- Ignored inputs:
  - start while busy has no effect.
  - start and abort together in IDLE/DONE: abort wins and the block stays or goes to IDLE.
- abort while busy: next state is IDLE next cycle. dut_in=0, busy=0, done=0, and signature holds its partial value. A SAMPLE in the same cycle as abort still emits sample_valid.
- reset at any time: immediate return to reset values, including dut_reset=0. No sweep resumes.
- Vector counter: N_IN+1 bits internally so the terminal compare does not wrap. dut_in never shows a value above 2^N_IN-1.

Test Plan:
1. Reset, then start with dut_out tied 0 and golden=0x0000. Expect:
   - 8 sample_valid strobes with sample_vec 0..7 in order;
   - signature=0x0000 and pass=1;
   - done after 18 cycles (SETTLE=1).
2. dut_out tied 1 with golden=0x00FF. Expect signature steps 0x0001,0x0003,…,0x00FF, and at done pass=1. Rerun with golden=0x00FE and expect pass=0.
3. dut_out=1 only when dut_in==3'b111. Expect signature=0x0001 and sample_bit=1 only on the strobe with sample_vec=7.
4. SETTLE=3. Expect each dut_in value held 3 cycles before its strobe, and done 34 cycles after start. Also check dut_reset is high exactly one cycle, while dut_in=0.
5. Assert abort after the 4th strobe. Expect:
   - IDLE next cycle with busy=0, done=0, dut_in=0, and signature equal to its 4-sample value;
   - a new start clears signature and sweeps from vec 0.
6. Mid-sweep:
   - start pulses are ignored and the strobe count stays 8;
   - asynchronous reset asserted between clock edges forces all outputs to 0 before the next CK edge.
